regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 124 ++++++++++++
 tb/tb_regfile_mp.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with PC alias, load scoreboard,
// same-cycle forwarding and a sticky dual-write conflict flag.
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 16,
  parameter int SP_INIT = 4,
  parameter int LR_INIT = 8,
  parameter int BYPASS  = 1,
  parameter int ADDR_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_b,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] ra3,
  input  logic [DATA_W-1:0] r15,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3,
  output logic              busy1,
  output logic              busy2,
  output logic              busy3,
  output logic              wr_conflict,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam logic [ADDR_W:0] PCX = (ADDR_W+1)'(NREG - 1);

  // Index NREG-1 is the PC alias and has no storage.
  logic [DATA_W-1:0] mem [0:NREG-2];
  logic [NREG-2:0]   pend;
  logic [NREG-2:0]   pend_nx;
  logic [ADDR_W:0]   cnt_nx;

  logic wa_ok;
  logic wb_ok;
  logic ps_ok;
  logic same;
  logic conflict;

  assign wa_ok    = we_a && ({1'b0, wa_a} < PCX);
  assign wb_ok    = we_b && ({1'b0, wb_ok_addr()} < PCX);
  assign ps_ok    = pend_set && ({1'b0, pend_addr} < PCX);
  assign same     = (wa_a == wa_b);
  assign conflict = wa_ok && wb_ok && same;

  function automatic logic [ADDR_W-1:0] wb_ok_addr();
    return wa_b;
  endfunction

  // Next scoreboard state: a load return clears, a new load mark wins.
  always_comb begin
    pend_nx = pend;
    if (wb_ok) pend_nx[wa_b] = 1'b0;
    if (ps_ok) pend_nx[pend_addr] = 1'b1;
  end

  // Population count of the next scoreboard state.
  always_comb begin
    cnt_nx = '0;
    for (int i = 0; i < NREG - 1; i++)
      cnt_nx = cnt_nx + (ADDR_W+1)'(pend_nx[i]);
  end

  // Register, scoreboard and flag state; port A wins a same-index clash.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG - 1; i++) mem[i] <= '0;
      mem[NREG-3] <= DATA_W'(SP_INIT);
      mem[NREG-2] <= DATA_W'(LR_INIT);
      pend        <= '0;
      pend_cnt    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (wb_ok && !conflict) mem[wa_b] <= wd_b;
      if (wa_ok) mem[wa_a] <= wd_a;
      pend     <= pend_nx;
      pend_cnt <= cnt_nx;
      if (conflict) wr_conflict <= 1'b1;
    end
  end

  logic [ADDR_W-1:0] ra   [3];
  logic [DATA_W-1:0] rd   [3];
  logic              busy [3];

  assign ra[0] = ra1;
  assign ra[1] = ra2;
  assign ra[2] = ra3;
  assign rd1   = rd[0];
  assign rd2   = rd[1];
  assign rd3   = rd[2];
  assign busy1 = busy[0];
  assign busy2 = busy[1];
  assign busy3 = busy[2];

  for (genvar g = 0; g < 3; g++) begin : g_rd
    // Read port: PC alias, forwarded write data, or stored value.
    always_comb begin
      rd[g]   = '0;
      busy[g] = 1'b0;
      if ({1'b0, ra[g]} == PCX) begin
        rd[g] = r15;
      end else if ({1'b0, ra[g]} < PCX) begin
        rd[g]   = mem[ra[g]];
        busy[g] = pend[ra[g]];
        if (BYPASS != 0) begin
          if (we_a && wa_a == ra[g])      rd[g] = wd_a;
          else if (we_b && wa_b == ra[g]) rd[g] = wd_b;
          if (we_b && wa_b == ra[g])      busy[g] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp with default parameters.
// Inputs change 1ns after a rising edge; outputs are sampled before the next.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_a, we_b, pend_set;
  logic [3:0]  wa_a, wa_b, ra1, ra2, ra3, pend_addr;
  logic [31:0] wd_a, wd_b, r15;
  logic [31:0] rd1, rd2, rd3;
  logic        busy1, busy2, busy3, wr_conflict;
  logic [4:0]  pend_cnt;

  int vecs = 0;
  int errs = 0;

  regfile_mp dut (
    .clk(clk), .reset(reset),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ra1(ra1), .ra2(ra2), .ra3(ra3), .r15(r15),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .busy1(busy1), .busy2(busy2), .busy3(busy3),
    .wr_conflict(wr_conflict), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 0; we_b = 0; pend_set = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); reset = 0;
    ra1 = 13; ra2 = 14; ra3 = 0; #1;
    vecs++;
    if (rd1 !== 32'd4) begin errs++; $display("FAIL rst_sp got %h want 4", rd1); end
    vecs++;
    if (rd2 !== 32'd8) begin errs++; $display("FAIL rst_lr got %h want 8", rd2); end
    vecs++;
    if (rd3 !== 32'd0) begin errs++; $display("FAIL rst_r0 got %h want 0", rd3); end
    vecs++;
    if ({busy1, busy2, busy3} !== 3'b000)
      begin errs++; $display("FAIL rst_busy got %b want 000", {busy1, busy2, busy3}); end
    vecs++;
    if (pend_cnt !== 5'd0) begin errs++; $display("FAIL rst_cnt got %0d want 0", pend_cnt); end
    vecs++;
    if (wr_conflict !== 1'b0) begin errs++; $display("FAIL rst_conf got %b want 0", wr_conflict); end
  endtask

  task automatic test_bypass();
    we_a = 1; wa_a = 3; wd_a = 32'hDEAD; ra1 = 3; #1;
    vecs++;
    if (rd1 !== 32'hDEAD) begin errs++; $display("FAIL byp_a got %h want dead", rd1); end
    tick(); idle(); #1;
    vecs++;
    if (rd1 !== 32'hDEAD) begin errs++; $display("FAIL stored_a got %h want dead", rd1); end
    we_b = 1; wa_b = 4; wd_b = 32'h44; ra1 = 4; #1;
    vecs++;
    if (rd1 !== 32'h44) begin errs++; $display("FAIL byp_b got %h want 44", rd1); end
    tick(); idle(); #1;
    vecs++;
    if (rd1 !== 32'h44) begin errs++; $display("FAIL stored_b got %h want 44", rd1); end
  endtask

  task automatic test_pending();
    pend_set = 1; pend_addr = 5; tick(); idle();
    ra2 = 5; #1;
    vecs++;
    if (busy2 !== 1'b1) begin errs++; $display("FAIL pend_busy got %b want 1", busy2); end
    vecs++;
    if (pend_cnt !== 5'd1) begin errs++; $display("FAIL pend_cnt1 got %0d want 1", pend_cnt); end
    we_b = 1; wa_b = 5; wd_b = 32'h77; #1;
    vecs++;
    if (busy2 !== 1'b0) begin errs++; $display("FAIL ld_busy got %b want 0", busy2); end
    vecs++;
    if (rd2 !== 32'h77) begin errs++; $display("FAIL ld_byp got %h want 77", rd2); end
    tick(); idle(); #1;
    vecs++;
    if (pend_cnt !== 5'd0) begin errs++; $display("FAIL pend_cnt0 got %0d want 0", pend_cnt); end
    vecs++;
    if (busy2 !== 1'b0) begin errs++; $display("FAIL ld_busy2 got %b want 0", busy2); end
  endtask

  task automatic test_set_wins();
    pend_set = 1; pend_addr = 6; we_b = 1; wa_b = 6; wd_b = 32'h66;
    tick(); idle(); ra1 = 6; #1;
    vecs++;
    if (busy1 !== 1'b1) begin errs++; $display("FAIL setwin_busy got %b want 1", busy1); end
    vecs++;
    if (pend_cnt !== 5'd1) begin errs++; $display("FAIL setwin_cnt got %0d want 1", pend_cnt); end
    vecs++;
    if (rd1 !== 32'h66) begin errs++; $display("FAIL setwin_data got %h want 66", rd1); end
    pend_set = 1; pend_addr = 7; tick(); idle();
    we_a = 1; wa_a = 7; wd_a = 32'h70; tick(); idle();
    ra3 = 7; #1;
    vecs++;
    if (busy3 !== 1'b1) begin errs++; $display("FAIL porta_keep got %b want 1", busy3); end
    vecs++;
    if (pend_cnt !== 5'd2) begin errs++; $display("FAIL porta_cnt got %0d want 2", pend_cnt); end
    vecs++;
    if (rd3 !== 32'h70) begin errs++; $display("FAIL porta_data got %h want 70", rd3); end
  endtask

  task automatic test_dual();
    we_a = 1; wa_a = 10; wd_a = 32'hA0; we_b = 1; wa_b = 11; wd_b = 32'hB1;
    tick(); idle(); ra1 = 10; ra2 = 11; #1;
    vecs++;
    if (rd1 !== 32'hA0) begin errs++; $display("FAIL dual_a got %h want a0", rd1); end
    vecs++;
    if (rd2 !== 32'hB1) begin errs++; $display("FAIL dual_b got %h want b1", rd2); end
    vecs++;
    if (wr_conflict !== 1'b0) begin errs++; $display("FAIL dual_conf got %b want 0", wr_conflict); end
  endtask

  task automatic test_conflict();
    int cnt0;
    cnt0 = 2;
    pend_set = 1; pend_addr = 2; tick(); idle();
    we_a = 1; wa_a = 2; wd_a = 32'd1; we_b = 1; wa_b = 2; wd_b = 32'd2;
    tick(); idle(); ra1 = 2; #1;
    vecs++;
    if (rd1 !== 32'd1) begin errs++; $display("FAIL conf_data got %h want 1", rd1); end
    vecs++;
    if (wr_conflict !== 1'b1) begin errs++; $display("FAIL conf_set got %b want 1", wr_conflict); end
    vecs++;
    if (busy1 !== 1'b0) begin errs++; $display("FAIL conf_pclr got %b want 0", busy1); end
    vecs++;
    if (pend_cnt !== 5'(cnt0))
      begin errs++; $display("FAIL conf_cnt got %0d want %0d", pend_cnt, cnt0); end
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++;
      if (wr_conflict !== 1'b1)
        begin errs++; $display("FAIL conf_sticky%0d got %b want 1", i, wr_conflict); end
    end
    reset = 1; tick(); reset = 0; #1;
    vecs++;
    if (wr_conflict !== 1'b0) begin errs++; $display("FAIL conf_rst got %b want 0", wr_conflict); end
    vecs++;
    if (rd1 !== 32'd0) begin errs++; $display("FAIL conf_rst_r2 got %h want 0", rd1); end
  endtask

  task automatic test_pc();
    r15 = 32'h108;
    we_a = 1; wa_a = 15; wd_a = 32'h55; we_b = 1; wa_b = 15; wd_b = 32'h55;
    pend_set = 1; pend_addr = 15; ra3 = 15; #1;
    vecs++;
    if (rd3 !== 32'h108) begin errs++; $display("FAIL pc_byp got %h want 108", rd3); end
    vecs++;
    if (busy3 !== 1'b0) begin errs++; $display("FAIL pc_busy got %b want 0", busy3); end
    tick(); idle(); #1;
    vecs++;
    if (wr_conflict !== 1'b0) begin errs++; $display("FAIL pc_conf got %b want 0", wr_conflict); end
    vecs++;
    if (pend_cnt !== 5'd0) begin errs++; $display("FAIL pc_cnt got %0d want 0", pend_cnt); end
    r15 = 32'h200; #1;
    vecs++;
    if (rd3 !== 32'h200) begin errs++; $display("FAIL pc_r15 got %h want 200", rd3); end
  endtask

  task automatic test_reset_mid();
    pend_set = 1; pend_addr = 1; we_a = 1; wa_a = 1; wd_a = 32'h11;
    tick(); idle();
    pend_set = 1; pend_addr = 9; tick(); idle(); #1;
    vecs++;
    if (pend_cnt !== 5'd2) begin errs++; $display("FAIL mid_cnt got %0d want 2", pend_cnt); end
    reset = 1; we_a = 1; wa_a = 13; wd_a = 32'h99; pend_set = 1; pend_addr = 3;
    tick(); reset = 0; idle();
    ra1 = 13; ra2 = 1; ra3 = 3; #1;
    vecs++;
    if (pend_cnt !== 5'd0) begin errs++; $display("FAIL mid_rcnt got %0d want 0", pend_cnt); end
    vecs++;
    if (rd1 !== 32'd4) begin errs++; $display("FAIL mid_sp got %h want 4", rd1); end
    vecs++;
    if ({busy2, busy3} !== 2'b00)
      begin errs++; $display("FAIL mid_busy got %b want 00", {busy2, busy3}); end
    vecs++;
    if (rd2 !== 32'd0) begin errs++; $display("FAIL mid_r1 got %h want 0", rd2); end
  endtask

  initial begin
    reset = 0; idle();
    wa_a = 0; wa_b = 0; wd_a = 0; wd_b = 0; pend_addr = 0;
    ra1 = 0; ra2 = 0; ra3 = 0; r15 = 0;
    #2;
    test_reset();
    test_bypass();
    test_pending();
    test_set_wins();
    test_dual();
    test_conflict();
    test_pc();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
